// File: rtl/bg_block_mem_ctrl_if.sv
// VRAM/DDR arbiter port used by the background block memory controller.
// One command channel (read or masked write beat) plus an in-order read return channel.
interface bg_block_mem_ctrl_if;
  logic        o_memCmdValid;
  logic        i_memCmdReady;
  logic        o_memWrite;
  logic [16:0] o_memAdr;
  logic [63:0] o_memWriteData;
  logic [7:0]  o_memByteEn;
  logic        i_memReadValid;
  logic [63:0] i_memReadData;

  modport master (
    output o_memCmdValid, o_memWrite, o_memAdr, o_memWriteData, o_memByteEn,
    input  i_memCmdReady, i_memReadValid, i_memReadData
  );

  modport slave (
    input  o_memCmdValid, o_memWrite, o_memAdr, o_memWriteData, o_memByteEn,
    output i_memCmdReady, i_memReadValid, i_memReadData
  );
endinterface

// File: rtl/bg_block_mem_ctrl.sv
// Saves 16-pixel background blocks to VRAM as masked 64-bit beats and loads them back,
// presenting a loaded block with a single-cycle import strobe.
module bg_block_mem_ctrl #(
  parameter int BEATS = 4
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic         i_saveReq,
  input  logic [14:0]  i_saveAdr,
  input  logic [255:0] i_saveBlock,
  input  logic [15:0]  i_saveMask,
  input  logic         i_loadReq,
  input  logic [14:0]  i_loadAdr,
  output logic         o_busy,
  output logic         o_importBGBlockSingleClock,
  output logic [255:0] o_importedBGBlock,
  bg_block_mem_ctrl_if.master mem
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR      = 3'd1;
  localparam logic [2:0] ST_RD_CMD  = 3'd2;
  localparam logic [2:0] ST_RD_WAIT = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;
  localparam logic [1:0] LAST_BEAT  = 2'(BEATS - 1);

  logic [2:0]   state_r;
  logic         busy_r;
  logic         importPulse_r;
  logic [255:0] imported_r;
  logic [191:0] rdBuf_r;
  logic [1:0]   retCnt_r;
  logic [14:0]  saveAdr_r;
  logic [255:0] block_r;
  logic [15:0]  mask_r;
  logic         loadPend_r;
  logic [14:0]  loadAdr_r;
  logic [1:0]   cmdBeat_r;
  logic         cmdValid_r;
  logic         cmdWrite_r;
  logic [16:0]  cmdAdr_r;
  logic [63:0]  cmdData_r;
  logic [7:0]   cmdByteEn_r;

  logic [2:0]   wrFirst_s;
  logic [2:0]   wrNext_s;
  logic         cmdFire_s;
  logic         rdActive_s;
  logic         retFire_s;

  // Byte enables of one beat: each pixel-mask bit covers two bytes.
  function automatic logic [7:0] beatByteEn(input logic [15:0] mask, input logic [1:0] beat);
    logic [3:0] nib;
    nib = mask[{beat, 2'b00} +: 4];
    return {{2{nib[3]}}, {2{nib[2]}}, {2{nib[1]}}, {2{nib[0]}}};
  endfunction

  // Lowest beat >= start with any mask bit set; MSB of result flags that one exists.
  function automatic logic [2:0] nextBeat(input logic [15:0] mask, input logic [2:0] start);
    logic [2:0] res;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      if ((3'(k) >= start) && (|mask[4*k +: 4])) begin
        res = {1'b1, 2'(k)};
      end
    end
    return res;
  endfunction

  assign wrFirst_s  = nextBeat(i_saveMask, 3'd0);
  assign wrNext_s   = nextBeat(mask_r, {1'b0, cmdBeat_r} + 3'd1);
  assign cmdFire_s  = cmdValid_r & mem.i_memCmdReady;
  assign rdActive_s = (state_r == ST_RD_CMD) || (state_r == ST_RD_WAIT);
  assign retFire_s  = rdActive_s & mem.i_memReadValid;

  assign o_busy                     = busy_r;
  assign o_importBGBlockSingleClock = importPulse_r;
  assign o_importedBGBlock          = imported_r;
  assign mem.o_memCmdValid          = cmdValid_r;
  assign mem.o_memWrite             = cmdWrite_r;
  assign mem.o_memAdr               = cmdAdr_r;
  assign mem.o_memWriteData         = cmdData_r;
  assign mem.o_memByteEn            = cmdByteEn_r;

  // Read-return assembly: beats land in order; the visible block only changes on the last beat.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      rdBuf_r    <= 192'd0;
      imported_r <= 256'd0;
    end else if (retFire_s) begin
      case (retCnt_r)
        2'd0:    rdBuf_r[63:0]    <= mem.i_memReadData;
        2'd1:    rdBuf_r[127:64]  <= mem.i_memReadData;
        2'd2:    rdBuf_r[191:128] <= mem.i_memReadData;
        default: imported_r       <= {mem.i_memReadData, rdBuf_r};
      endcase
    end
  end

  // Request acceptance, command sequencing and completion FSM.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_r       <= ST_IDLE;
      busy_r        <= 1'b0;
      importPulse_r <= 1'b0;
      retCnt_r      <= 2'd0;
      saveAdr_r     <= 15'd0;
      block_r       <= 256'd0;
      mask_r        <= 16'd0;
      loadPend_r    <= 1'b0;
      loadAdr_r     <= 15'd0;
      cmdBeat_r     <= 2'd0;
      cmdValid_r    <= 1'b0;
      cmdWrite_r    <= 1'b0;
      cmdAdr_r      <= 17'd0;
      cmdData_r     <= 64'd0;
      cmdByteEn_r   <= 8'd0;
    end else begin
      importPulse_r <= 1'b0;
      if (retFire_s) begin
        retCnt_r <= retCnt_r + 2'd1;
      end
      case (state_r)
        ST_IDLE: begin
          // An all-zero save mask makes the save vanish; a paired load still runs.
          if (!busy_r && i_saveReq && wrFirst_s[2]) begin
            saveAdr_r   <= i_saveAdr;
            block_r     <= i_saveBlock;
            mask_r      <= i_saveMask;
            loadPend_r  <= i_loadReq;
            loadAdr_r   <= i_loadAdr;
            state_r     <= ST_WR;
            busy_r      <= 1'b1;
            cmdValid_r  <= 1'b1;
            cmdWrite_r  <= 1'b1;
            cmdBeat_r   <= wrFirst_s[1:0];
            cmdAdr_r    <= {i_saveAdr, wrFirst_s[1:0]};
            cmdData_r   <= i_saveBlock[{wrFirst_s[1:0], 6'd0} +: 64];
            cmdByteEn_r <= beatByteEn(i_saveMask, wrFirst_s[1:0]);
          end else if (!busy_r && i_loadReq) begin
            loadAdr_r   <= i_loadAdr;
            state_r     <= ST_RD_CMD;
            busy_r      <= 1'b1;
            retCnt_r    <= 2'd0;
            cmdValid_r  <= 1'b1;
            cmdWrite_r  <= 1'b0;
            cmdBeat_r   <= 2'd0;
            cmdAdr_r    <= {i_loadAdr, 2'd0};
            cmdData_r   <= 64'd0;
            cmdByteEn_r <= 8'hFF;
          end
        end
        ST_WR: begin
          if (cmdFire_s) begin
            if (wrNext_s[2]) begin
              cmdBeat_r   <= wrNext_s[1:0];
              cmdAdr_r    <= {saveAdr_r, wrNext_s[1:0]};
              cmdData_r   <= block_r[{wrNext_s[1:0], 6'd0} +: 64];
              cmdByteEn_r <= beatByteEn(mask_r, wrNext_s[1:0]);
            end else if (loadPend_r) begin
              loadPend_r  <= 1'b0;
              state_r     <= ST_RD_CMD;
              retCnt_r    <= 2'd0;
              cmdWrite_r  <= 1'b0;
              cmdBeat_r   <= 2'd0;
              cmdAdr_r    <= {loadAdr_r, 2'd0};
              cmdData_r   <= 64'd0;
              cmdByteEn_r <= 8'hFF;
            end else begin
              state_r     <= ST_IDLE;
              busy_r      <= 1'b0;
              cmdValid_r  <= 1'b0;
              cmdWrite_r  <= 1'b0;
              cmdAdr_r    <= 17'd0;
              cmdData_r   <= 64'd0;
              cmdByteEn_r <= 8'd0;
            end
          end
        end
        ST_RD_CMD: begin
          if (cmdFire_s) begin
            if (cmdBeat_r == LAST_BEAT) begin
              state_r     <= ST_RD_WAIT;
              cmdValid_r  <= 1'b0;
              cmdAdr_r    <= 17'd0;
              cmdByteEn_r <= 8'd0;
            end else begin
              cmdBeat_r   <= cmdBeat_r + 2'd1;
              cmdAdr_r    <= {loadAdr_r, cmdBeat_r + 2'd1};
            end
          end
        end
        ST_RD_WAIT: begin
          if (retFire_s && (retCnt_r == LAST_BEAT)) begin
            state_r       <= ST_DONE;
            importPulse_r <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r    <= ST_IDLE;
          busy_r     <= 1'b0;
          cmdValid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
